// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources.
// The transmitter has no busy/done output, so the arbiter times each frame plus guard gap itself.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       grant_id
);

  localparam int SLOT_CLKS = (FRAME_BITS + GAP_BITS) * CLKS_PER_BIT;
  localparam int CNT_W     = $clog2(SLOT_CLKS) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((FRAME_BITS + GAP_BITS - 1) * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             last_grant_r, last_grant_s;
  logic [7:0]       tx_data_s;
  logic             tx_start_s;
  logic             busy_s;
  logic             grant_id_s;
  logic             ack0_s;
  logic             ack1_s;
  logic             pick1_s;

  // Round-robin choice: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick1_s = 1'b0;
    if (req1 && (!req0 || !last_grant_r)) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
  end

  // Next-state and next-output logic; everything holds unless a transition says otherwise.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    last_grant_s = last_grant_r;
    tx_data_s    = tx_data;
    tx_start_s   = tx_start;
    busy_s       = busy;
    grant_id_s   = grant_id;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          tx_data_s    = pick1_s ? data1 : data0;
          grant_id_s   = pick1_s;
          last_grant_s = pick1_s;
          ack0_s       = !pick1_s;
          ack1_s       = pick1_s;
          tx_start_s   = 1'b1;
          busy_s       = 1'b1;
          count_s      = CNT_ZERO;
          state_s      = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // transmit_signal stays high for a full bit so the transmitter's baud tick sees it
        if (count_r == START_LAST) begin
          tx_start_s = 1'b0;
          count_s    = CNT_ZERO;
          state_s    = ST_WAIT;
        end else begin
          count_s = count_r + CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (count_r == WAIT_LAST) begin
          busy_s  = 1'b0;
          count_s = CNT_ZERO;
          state_s = ST_IDLE;
        end else begin
          count_s = count_r + CNT_ONE;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        count_s    = CNT_ZERO;
        tx_start_s = 1'b0;
        busy_s     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset mid-frame abandons the byte at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      count_r      <= CNT_ZERO;
      last_grant_r <= 1'b1;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      last_grant_r <= last_grant_s;
      tx_data      <= tx_data_s;
      tx_start     <= tx_start_s;
      busy         <= busy_s;
      grant_id     <= grant_id_s;
      ack0         <= ack0_s;
      ack1         <= ack1_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: slot-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations on order, spacing and pulse lengths.
module tb_uart_tx_arbiter;

  localparam int CPB  = 4;
  localparam int FB   = 10;
  localparam int GB   = 1;
  localparam int SLOT = (FB + GB) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       ack0, ack1, tx_start, busy, grant_id;
  logic [7:0] tx_data;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_BITS(GB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a grant starts a slot of SLOT busy cycles, the first CPB with tx_start high.
  int         m_busy_left = 0;
  int         m_start_left = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_gid = 1'b0;
  logic       m_last = 1'b1;
  logic       m_ack0 = 1'b0;
  logic       m_ack1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy_left <= 0; m_start_left <= 0; m_data <= 8'h00;
      m_gid <= 1'b0; m_last <= 1'b1; m_ack0 <= 1'b0; m_ack1 <= 1'b0;
    end else begin
      m_ack0 <= 1'b0;
      m_ack1 <= 1'b0;
      if (m_busy_left > 0) begin
        m_busy_left <= m_busy_left - 1;
        if (m_start_left > 0) m_start_left <= m_start_left - 1;
      end else if (req0 || req1) begin
        if (req1 && (!req0 || m_last == 1'b0)) begin
          m_data <= data1; m_gid <= 1'b1; m_last <= 1'b1; m_ack1 <= 1'b1;
        end else begin
          m_data <= data0; m_gid <= 1'b0; m_last <= 1'b0; m_ack0 <= 1'b1;
        end
        m_busy_left  <= SLOT;
        m_start_left <= CPB;
      end
    end
  end

  // Observation log of accepted bytes, plus run-length counters.
  logic [7:0] log_byte[$];
  int         log_time[$];
  logic       log_id[$];
  logic [7:0] exp_q[$];
  int         busy_cnt = 0;
  int         start_cnt = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("ack0", ack0, m_ack0);
      chk("ack1", ack1, m_ack1);
      chk("tx_data", tx_data, m_data);
      chk("tx_start", tx_start, (m_start_left > 0) ? 1 : 0);
      chk("busy", busy, (m_busy_left > 0) ? 1 : 0);
      chk("grant_id", grant_id, m_gid);
    end
    if (ack0 === 1'b1 || ack1 === 1'b1) begin
      log_byte.push_back(tx_data);
      log_time.push_back(cyc);
      log_id.push_back(ack1);
    end
    if (busy === 1'b1) busy_cnt++;
    if (tx_start === 1'b1) start_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_byte.delete(); log_time.delete(); log_id.delete();
  endtask

  task automatic wait_ack(input string name, input bit which);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if ((which ? ack1 : ack0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (busy === 1'b0) break;
    end
    chk(name, busy, 0);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_byte.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_byte.size(); i++)
      chk({name, "_byte"}, log_byte[i], exp_q[i]);
  endtask

  task automatic check_spacing(input string name);
    for (int i = 1; i < log_time.size(); i++)
      chk(name, log_time[i] - log_time[i-1], SLOT + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then quiet idle
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ack0", ack0, 0); chk("rst_ack1", ack1, 0);
    chk("rst_tx_data", tx_data, 8'h00); chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0); chk("rst_grant_id", grant_id, 0);
    reset = 1'b1;
    clear_log();
    step(100);
    chk("idle_no_grant", log_byte.size(), 0);
    chk("idle_busy", busy, 0);

    // 2: single byte from requester 0
    busy_cnt = 0; start_cnt = 0;
    data0 = 8'hA5; req0 = 1'b1;
    wait_ack("t2_ack0", 1'b0);
    req0 = 1'b0;
    chk("t2_tx_data", tx_data, 8'hA5);
    wait_idle("t2_idle");
    step(5);
    chk("t2_busy_len", busy_cnt, 44);
    chk("t2_start_len", start_cnt, 4);
    exp_q.delete(); exp_q.push_back(8'hA5);
    check_log("t2_log");

    // 3: both requesting from reset -> alternation
    reset = 1'b0;
    clear_log();
    data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
    step(2);
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (log_byte.size() >= 4) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    check_log("t3_order");
    for (int i = 0; i < 4 && i < log_id.size(); i++) chk("t3_ack_id", log_id[i], i % 2);
    check_spacing("t3_spacing");

    // 4: req1 withdrawn while busy leaves no trace
    wait_idle("t4_idle0");
    clear_log();
    data0 = 8'h3C; req0 = 1'b1;
    wait_ack("t4_ack0", 1'b0);
    req0 = 1'b0;
    step(10);
    data1 = 8'h77; req1 = 1'b1;
    step(5);
    req1 = 1'b0;
    wait_idle("t4_idle1");
    step(60);
    exp_q.delete(); exp_q.push_back(8'h3C);
    check_log("t4_log");
    chk("t4_tx_data", tx_data, 8'h3C);

    // 5: async reset on cycle 10 of a frame, pending req0 regranted after release
    wait_idle("t5_idle");
    data0 = 8'h5A; req0 = 1'b1;
    wait_ack("t5_ack0", 1'b0);
    step(9);
    chk("t5_busy_before", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_busy_async", busy, 0);
    chk("t5_start_async", tx_start, 0);
    chk("t5_data_async", tx_data, 8'h00);
    clear_log();
    step(2);
    reset = 1'b1;
    wait_ack("t5_regrant", 1'b0);
    req0 = 1'b0;
    chk("t5_tx_data", tx_data, 8'h5A);
    chk("t5_grant_id", grant_id, 0);

    // 6: streaming req0 with data changed after each ack
    wait_idle("t6_idle0");
    clear_log();
    exp_q.delete();
    exp_q.push_back(8'h81); exp_q.push_back(8'h42); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h24); exp_q.push_back(8'hE5);
    data0 = exp_q[0]; req0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_ack("t6_ack0", 1'b0);
      if (k < 4) data0 = exp_q[k+1];
      else req0 = 1'b0;
    end
    wait_idle("t6_idle1");
    step(50);
    check_log("t6_stream");
    check_spacing("t6_spacing");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
